// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed, XOR-checked byte stream into IMEM, then releases the core reset.
module imem_boot_loader #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_write_en,
    output logic [ADDR_W-1:0] imem_write_addr,
    output logic [31:0]       imem_write_data,
    output logic              rst_im,
    output logic              core_rst,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code
);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    typedef enum logic [3:0] {IDLE, CLR, LEN0, LEN1, DATA, WRITE, CSUM, RUN, ERROR} state_t;
    state_t state, state_n;
    logic [1:0] code_n;
    logic [ADDR_W:0] addr;
    logic [15:0] len;
    logic [7:0] len_lo, csum;
    logic [1:0] byte_idx;
    logic [TW-1:0] tcnt;
    logic xfer, loading, expire;
    logic [15:0] len_n;
    assign xfer    = byte_valid & byte_ready;
    assign loading = state inside {LEN0, LEN1, DATA, CSUM};
    assign expire  = loading && !xfer && tcnt == TW'(TIMEOUT_CYC - 2);
    assign len_n   = {byte_data, len_lo};
    assign imem_write_addr = addr[ADDR_W-1:0];
    always_comb begin
        state_n = state;
        code_n  = error_code;
        if (expire) begin
            state_n = ERROR;
            code_n  = 2'd3;
        end else begin
            case (state)
                IDLE, RUN, ERROR: state_n = start ? CLR : state;
                CLR: begin
                    state_n = LEN0;
                    code_n  = 2'd0;
                end
                LEN0: state_n = xfer ? LEN1 : LEN0;
                LEN1: if (xfer) begin
                    state_n = (32'(len_n) > 32'(2**ADDR_W)) ? ERROR : (len_n == 16'd0) ? CSUM : DATA;
                    code_n  = (32'(len_n) > 32'(2**ADDR_W)) ? 2'd1 : error_code;
                end
                DATA: state_n = (xfer && byte_idx == 2'd3) ? WRITE : DATA;
                WRITE: state_n = (32'(addr) + 32'd1 == 32'(len)) ? CSUM : DATA;
                CSUM: if (xfer) begin
                    state_n = (byte_data == csum) ? RUN : ERROR;
                    code_n  = (byte_data == csum) ? error_code : 2'd2;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            core_rst        <= 1'b1;
            rst_im          <= 1'b0;
            imem_write_en   <= 1'b0;
            byte_ready      <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            error_code      <= 2'd0;
            imem_write_data <= '0;
            addr            <= '0;
            len             <= '0;
            len_lo          <= '0;
            csum            <= '0;
            byte_idx        <= '0;
            tcnt            <= '0;
        end else begin
            state         <= state_n;
            error_code    <= code_n;
            byte_ready    <= state_n inside {LEN0, LEN1, DATA, CSUM};
            rst_im        <= state_n == CLR;
            imem_write_en <= state_n == WRITE;
            done          <= state_n == RUN;
            error         <= state_n == ERROR;
            core_rst      <= state_n != RUN;
            if (state == CLR) begin
                addr            <= '0;
                len             <= '0;
                csum            <= '0;
                byte_idx        <= '0;
                tcnt            <= '0;
                imem_write_data <= '0;
            end else begin
                tcnt <= (loading && !xfer) ? tcnt + 1'b1 : '0;
                if (xfer && state != CSUM) csum <= csum ^ byte_data;
                if (xfer && state == LEN0) len_lo <= byte_data;
                if (xfer && state == LEN1) len <= len_n;
                // byte 0 ends up in [7:0] after four right-shifts
                if (xfer && state == DATA) begin
                    imem_write_data <= {byte_data, imem_write_data[31:8]};
                    byte_idx        <= byte_idx + 2'd1;
                end
                if (state == WRITE) addr <= addr + 1'b1;
            end
        end
    end
endmodule
